tlb_ctrl_gen2: RTL and testbench

TLB_CTRL_GEN2 -- requirements
Module: tlb_ctrl_gen2

---
 rtl/tlb_ctrl_gen2.sv | 160 ++++++++++++++++
 tb/tb_tlb_ctrl_gen2.sv | 299 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tlb_ctrl_gen2.sv
// rtl/tlb_ctrl_gen2.sv - TLB miss/flush control FSM sequencing lookup, page-table walk, update and response
module tlb_ctrl_gen2 #(
  parameter int TLB_ENTRIES = 16,
  parameter int PTW_TIMEOUT = 255,
  localparam int IDX_W = $clog2(TLB_ENTRIES),
  localparam int TO_W  = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid_i,
  output logic             req_ready_o,
  output logic             resp_valid_o,
  input  logic             resp_ready_i,
  output logic [1:0]       resp_fault_o,
  input  logic             flush_valid_i,
  output logic             flush_ready_o,
  output logic             ptw_req_valid_o,
  input  logic             ptw_req_ready_i,
  input  logic             ptw_resp_valid_i,
  output logic             ptw_resp_ready_o,
  input  logic             ptw_resp_err_i,
  input  logic             hit_i,
  input  logic             perm_fault_i,
  output logic             lookup_en_o,
  output logic             update_en_o,
  output logic             lru_update_en_o,
  output logic             flush_en_o,
  output logic [IDX_W-1:0] flush_idx_o,
  output logic [2:0]       state_o,
  output logic             busy_o
);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_LOOKUP   = 3'd1,
    S_PTW_REQ  = 3'd2,
    S_PTW_WAIT = 3'd3,
    S_UPDATE   = 3'd4,
    S_RESPOND  = 3'd5,
    S_FLUSH    = 3'd6
  } state_t;

  localparam logic [1:0] F_OK      = 2'b00;
  localparam logic [1:0] F_PERM    = 2'b01;
  localparam logic [1:0] F_PTW_ERR = 2'b10;
  localparam logic [1:0] F_PTW_TO  = 2'b11;

  localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(PTW_TIMEOUT - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(TLB_ENTRIES - 1);

  state_t            state_q, state_d;
  logic [TO_W-1:0]   cnt_q, cnt_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [1:0]        fault_q, fault_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      fault_q <= F_OK;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      fault_q <= fault_d;
    end
  end

  always_comb begin
    state_d          = state_q;
    cnt_d            = cnt_q;
    idx_d            = idx_q;
    fault_d          = fault_q;
    req_ready_o      = 1'b0;
    flush_ready_o    = 1'b0;
    resp_valid_o     = 1'b0;
    ptw_req_valid_o  = 1'b0;
    ptw_resp_ready_o = 1'b0;
    lookup_en_o      = 1'b0;
    update_en_o      = 1'b0;
    lru_update_en_o  = 1'b0;
    flush_en_o       = 1'b0;
    case (state_q)
      S_IDLE: begin
        flush_ready_o = 1'b1;
        req_ready_o   = !flush_valid_i;
        if (flush_valid_i) begin
          state_d = S_FLUSH;
          idx_d   = '0;
        end else if (req_valid_i) begin
          state_d = S_LOOKUP;
        end
      end
      S_LOOKUP: begin
        lookup_en_o = 1'b1;
        if (hit_i) begin
          state_d = S_RESPOND;
          if (perm_fault_i) begin
            fault_d = F_PERM;
          end else begin
            fault_d         = F_OK;
            lru_update_en_o = 1'b1;
          end
        end else begin
          state_d = S_PTW_REQ;
        end
      end
      S_PTW_REQ: begin
        ptw_req_valid_o = 1'b1;
        if (ptw_req_ready_i) begin
          state_d = S_PTW_WAIT;
          cnt_d   = '0;
        end
      end
      S_PTW_WAIT: begin
        ptw_resp_ready_o = 1'b1;
        // A response in the expiry cycle is checked first so it beats the timeout.
        if (ptw_resp_valid_i) begin
          if (ptw_resp_err_i) begin
            state_d = S_RESPOND;
            fault_d = F_PTW_ERR;
          end else begin
            state_d = S_UPDATE;
          end
        end else if (PTW_TIMEOUT != 0 && cnt_q == TO_LAST) begin
          state_d = S_RESPOND;
          fault_d = F_PTW_TO;
        end else begin
          cnt_d = cnt_q + TO_W'(1);
        end
      end
      S_UPDATE: begin
        update_en_o     = 1'b1;
        lru_update_en_o = 1'b1;
        state_d         = S_RESPOND;
        fault_d         = F_OK;
      end
      S_RESPOND: begin
        resp_valid_o = 1'b1;
        if (resp_ready_i) begin
          state_d = S_IDLE;
          fault_d = F_OK;
        end
      end
      S_FLUSH: begin
        flush_en_o = 1'b1;
        idx_d      = idx_q + IDX_W'(1);
        if (idx_q == IDX_LAST) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign resp_fault_o = fault_q;
  assign flush_idx_o  = (state_q == S_FLUSH) ? idx_q : '0;
  assign state_o      = state_q;
  assign busy_o       = (state_q != S_IDLE);

endmodule

// File: tb/tb_tlb_ctrl_gen2.sv
// tb/tb_tlb_ctrl_gen2.sv - randomized transaction-level bench for tlb_ctrl_gen2
module tb_tlb_ctrl_gen2;
  localparam int TLB = 16;
  localparam int TO  = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic       req_valid_i, req_ready_o, resp_valid_o, resp_ready_i;
  logic [1:0] resp_fault_o;
  logic       flush_valid_i, flush_ready_o;
  logic       ptw_req_valid_o, ptw_req_ready_i, ptw_resp_valid_i, ptw_resp_ready_o, ptw_resp_err_i;
  logic       hit_i, perm_fault_i;
  logic       lookup_en_o, update_en_o, lru_update_en_o, flush_en_o;
  logic [3:0] flush_idx_o;
  logic [2:0] state_o;
  logic       busy_o;

  int checks = 0;
  int errors = 0;

  tlb_ctrl_gen2 #(.TLB_ENTRIES(TLB), .PTW_TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
    .resp_valid_o(resp_valid_o), .resp_ready_i(resp_ready_i), .resp_fault_o(resp_fault_o),
    .flush_valid_i(flush_valid_i), .flush_ready_o(flush_ready_o),
    .ptw_req_valid_o(ptw_req_valid_o), .ptw_req_ready_i(ptw_req_ready_i),
    .ptw_resp_valid_i(ptw_resp_valid_i), .ptw_resp_ready_o(ptw_resp_ready_o),
    .ptw_resp_err_i(ptw_resp_err_i),
    .hit_i(hit_i), .perm_fault_i(perm_fault_i),
    .lookup_en_o(lookup_en_o), .update_en_o(update_en_o),
    .lru_update_en_o(lru_update_en_o), .flush_en_o(flush_en_o),
    .flush_idx_o(flush_idx_o), .state_o(state_o), .busy_o(busy_o)
  );

  always #5 clk = ~clk;

  // One translation: the walker and processor react cycle by cycle; expectations come from the rules.
  task automatic run_txn(input bit hit, input bit perm, input int rdy_dly, input int rsp_dly,
                         input bit err, input int stall, input bit hold_flush, input string name);
    int t = 0, t_acc = -1, t_rsp = -1, rq = 0, wc = 0, lk = 0, up = 0, lru = 0, rv = 0;
    bit acc = 0, done = 0;
    logic [1:0] fault0 = 2'b00;
    logic [1:0] exp_code;
    int exp_up, exp_lru, exp_rq, exp_wc, exp_lat;
    bit walk_ok = (rsp_dly < TO);
    if (hit) exp_code = perm ? 2'b01 : 2'b00;
    else if (!walk_ok) exp_code = 2'b11;
    else exp_code = err ? 2'b10 : 2'b00;
    exp_up  = (!hit && walk_ok && !err) ? 1 : 0;
    exp_lru = ((hit && !perm) || exp_up == 1) ? 1 : 0;
    exp_rq  = hit ? 0 : rdy_dly + 1;
    exp_wc  = hit ? 0 : (walk_ok ? rsp_dly + 1 : TO);
    exp_lat = 2 + exp_rq + exp_wc + exp_up;
    while (!done && t < 300) begin
      @(negedge clk);
      req_valid_i      = !acc;
      hit_i            = hit;
      perm_fault_i     = perm;
      flush_valid_i    = hold_flush && acc;
      ptw_req_ready_i  = ptw_req_valid_o && (rq == rdy_dly);
      ptw_resp_err_i   = err;
      ptw_resp_valid_i = 1'b0;
      resp_ready_i     = 1'b0;
      if (ptw_req_valid_o) rq++;
      if (ptw_resp_ready_o) begin
        ptw_resp_valid_i = (wc == rsp_dly);
        wc++;
      end
      if (resp_valid_o) begin
        ptw_resp_valid_i = 1'($urandom_range(0, 1));
        resp_ready_i = (rv == stall);
        done = (rv == stall);
      end
      #1;
      if (lookup_en_o) lk++;
      if (update_en_o) up++;
      if (lru_update_en_o) lru++;
      if (acc && hold_flush) begin
        checks++;
        if (flush_ready_o !== 1'b0) begin
          errors++;
          $display("FAIL %s flush_holdoff: flush_ready_o=%b required 0", name, flush_ready_o);
        end
      end
      if (resp_valid_o) begin
        if (rv == 0) begin
          t_rsp = t;
          fault0 = resp_fault_o;
        end else begin
          checks++;
          if (resp_fault_o !== fault0) begin
            errors++;
            $display("FAIL %s fault_stable: %b required %b", name, resp_fault_o, fault0);
          end
        end
        checks++;
        if (ptw_resp_ready_o !== 1'b0) begin
          errors++;
          $display("FAIL %s late_ptw_ack: ptw_resp_ready_o=%b required 0", name, ptw_resp_ready_o);
        end
        rv++;
      end
      if (!acc && req_ready_o) begin
        acc = 1;
        t_acc = t;
      end
      t++;
    end
    checks++;
    if (!done) begin
      errors++;
      $display("FAIL %s no_response: done=%0d required 1 within 300 cycles", name, done);
    end else begin
      checks++;
      if (fault0 !== exp_code) begin
        errors++;
        $display("FAIL %s code: %b required %b", name, fault0, exp_code);
      end
      checks++;
      if (t_rsp - t_acc !== exp_lat) begin
        errors++;
        $display("FAIL %s latency: %0d required %0d", name, t_rsp - t_acc, exp_lat);
      end
      checks++;
      if ({lk, up, lru, rq, wc, rv} !== {32'd1, exp_up, exp_lru, exp_rq, exp_wc, stall + 1}) begin
        errors++;
        $display("FAIL %s counts: lk=%0d up=%0d lru=%0d rq=%0d wc=%0d rv=%0d required 1 %0d %0d %0d %0d %0d",
                 name, lk, up, lru, rq, wc, rv, exp_up, exp_lru, exp_rq, exp_wc, stall + 1);
      end
    end
    @(negedge clk);
    req_valid_i = 0; resp_ready_i = 0; ptw_resp_valid_i = 0; ptw_req_ready_i = 0;
    #1;
    checks++;
    if ({busy_o, state_o, resp_fault_o} !== 6'd0) begin
      errors++;
      $display("FAIL %s back_idle: busy=%b state=%0d fault=%b required 0 0 00", name, busy_o, state_o, resp_fault_o);
    end
  endtask

  // Flush sweep; with_req keeps a request pending and checks it is held off then accepted afterwards.
  task automatic run_flush(input bit with_req, input string name);
    int t = 0, cnt = 0;
    bit done = 0;
    flush_valid_i = 1'b1;
    req_valid_i = with_req;
    hit_i = 1'b1;
    perm_fault_i = 1'b0;
    while (!done && t < 100) begin
      @(negedge clk);
      #1;
      if (flush_en_o) begin
        checks++;
        if ({flush_idx_o, req_ready_o, flush_ready_o, busy_o} !== {4'(cnt), 3'b001}) begin
          errors++;
          $display("FAIL %s flush_step: idx=%0d rr=%b fr=%b busy=%b required %0d 0 0 1",
                   name, flush_idx_o, req_ready_o, flush_ready_o, busy_o, cnt);
        end
        flush_valid_i = 1'b0;
        cnt++;
      end else if (cnt > 0) begin
        done = 1;
      end
      t++;
    end
    checks++;
    if (cnt !== TLB) begin
      errors++;
      $display("FAIL %s flush_len: %0d cycles required %0d", name, cnt, TLB);
    end
    checks++;
    if ({state_o, req_ready_o} !== {3'd0, 1'b1}) begin
      errors++;
      $display("FAIL %s post_flush: state=%0d req_ready=%b required 0 1", name, state_o, req_ready_o);
    end
    flush_valid_i = 1'b0;
  endtask

  task automatic test_reset();
    logic [18:0] exp_v = {2'b11, 17'd0};
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
    checks++;
    if ({req_ready_o, flush_ready_o, busy_o, resp_valid_o, resp_fault_o, ptw_req_valid_o, ptw_resp_ready_o,
         lookup_en_o, update_en_o, lru_update_en_o, flush_en_o, flush_idx_o, state_o} !== exp_v) begin
      errors++;
      $display("FAIL reset_outputs: rr=%b fr=%b busy=%b rv=%b state=%0d required 1 1 0 0 0",
               req_ready_o, flush_ready_o, busy_o, resp_valid_o, state_o);
    end
  endtask

  task automatic test_directed();
    run_txn(1, 0, 0, 0, 0, 3, 0, "hit");
    run_txn(1, 1, 0, 0, 0, 0, 0, "perm");
    run_txn(0, 0, 3, 1, 0, 0, 0, "miss");
    run_txn(0, 0, 0, 10, 0, 1, 0, "timeout");
    run_txn(0, 0, 1, 2, 1, 0, 0, "ptw_err");
    run_txn(0, 0, 0, TO - 1, 0, 0, 0, "resp_at_expiry");
    run_txn(0, 1, 2, TO, 1, 2, 0, "just_expired");
  endtask

  task automatic test_flush_priority();
    run_flush(1, "flush_vs_req");
    @(negedge clk);
    req_valid_i = 1'b0;
    #1;
    checks++;
    if ({lookup_en_o, lru_update_en_o} !== 2'b11) begin
      errors++;
      $display("FAIL flush_req_lookup: lookup=%b lru=%b required 1 1", lookup_en_o, lru_update_en_o);
    end
    @(negedge clk);
    resp_ready_i = 1'b1;
    #1;
    checks++;
    if ({resp_valid_o, resp_fault_o} !== 3'b100) begin
      errors++;
      $display("FAIL flush_req_resp: valid=%b code=%b required 1 00", resp_valid_o, resp_fault_o);
    end
    @(negedge clk);
    resp_ready_i = 1'b0;
  endtask

  task automatic test_flush_holdoff();
    run_txn(0, 0, 1, 1, 0, 2, 1, "holdoff_miss");
    run_flush(0, "holdoff_flush");
  endtask

  task automatic test_reset_mid();
    logic [18:0] exp_v = {2'b11, 17'd0};
    int t = 0;
    @(negedge clk);
    req_valid_i = 1'b1; hit_i = 1'b0; ptw_req_ready_i = 1'b1;
    @(negedge clk);
    req_valid_i = 1'b0;
    while (!ptw_resp_ready_o && t < 20) begin
      @(negedge clk);
      t++;
    end
    checks++;
    if (ptw_resp_ready_o !== 1'b1) begin
      errors++;
      $display("FAIL reach_ptw_wait: ptw_resp_ready_o=%b required 1", ptw_resp_ready_o);
    end
    rst = 1'b1; ptw_req_ready_i = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    #1;
    checks++;
    if ({req_ready_o, flush_ready_o, busy_o, resp_valid_o, resp_fault_o, ptw_req_valid_o, ptw_resp_ready_o,
         lookup_en_o, update_en_o, lru_update_en_o, flush_en_o, flush_idx_o, state_o} !== exp_v) begin
      errors++;
      $display("FAIL reset_mid_ptw: state=%0d busy=%b rv=%b required 0 0 0", state_o, busy_o, resp_valid_o);
    end
    run_txn(1, 0, 0, 0, 0, 0, 0, "hit_after_reset");
    flush_valid_i = 1'b1;
    t = 0;
    while (flush_idx_o != 4'd5 && t < 40) begin
      @(negedge clk);
      flush_valid_i = 1'b0;
      t++;
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1;
    checks++;
    if ({busy_o, flush_en_o, flush_idx_o, req_ready_o} !== 7'b0000001) begin
      errors++;
      $display("FAIL reset_mid_flush: busy=%b flush_en=%b idx=%0d rr=%b required 0 0 0 1",
               busy_o, flush_en_o, flush_idx_o, req_ready_o);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 40; i++) begin
      bit hf = ($urandom_range(0, 4) == 0);
      run_txn(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom_range(0, 3),
              $urandom_range(0, TO + 2), 1'($urandom_range(0, 1)), $urandom_range(0, 2), hf, "random");
      if (hf) run_flush(0, "random_flush");
    end
  endtask

  initial begin
    rst = 1'b1;
    req_valid_i = 0; resp_ready_i = 0; flush_valid_i = 0; ptw_req_ready_i = 0;
    ptw_resp_valid_i = 0; ptw_resp_err_i = 0; hit_i = 0; perm_fault_i = 0;
    test_reset();
    test_directed();
    test_flush_priority();
    test_flush_holdoff();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
